hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/lc3b_types.sv | 16 +
 rtl/hazard_control_if.sv | 43 ++++
 rtl/load_use_detect.sv | 24 ++
 rtl/hazard_control.sv | 107 ++++++++++
 tb/tb_hazard_control.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register numbers and hazard-controller state.
package lc3b_types;

   localparam int unsigned REG_W       = 3;
   localparam int unsigned STALL_CNT_W = 16;

   typedef logic [REG_W-1:0] lc3b_reg;

   typedef enum logic [1:0] {
      HZ_RUN       = 2'd0,
      HZ_DMEM_WAIT = 2'd1,
      HZ_IMEM_WAIT = 2'd2,
      HZ_REDIRECT  = 2'd3
   } lc3b_hz_state;

endpackage

// File: rtl/hazard_control_if.sv
// Pipeline <-> hazard controller signal bundle; slave is the controller side.
interface hazard_control_if;
   import lc3b_types::*;

   logic                   needs_sr1_ID;
   logic                   needs_sr2_ID;
   lc3b_reg                sr1_ID;
   lc3b_reg                sr2_ID;
   logic                   memread_EX;
   logic                   regwrite_EX;
   lc3b_reg                destreg_EX;
   logic                   imem_busy;
   logic                   dmem_busy;
   logic                   redirect_MEM;

   logic                   load_pc;
   logic                   load_IF_ID;
   logic                   load_ID_EX;
   logic                   load_EX_MEM;
   logic                   load_MEM_WB;
   logic                   bubble_ID_EX;
   logic                   flush_IF_ID;
   logic                   redirect_pc;
   lc3b_hz_state           hz_state;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output needs_sr1_ID, needs_sr2_ID, sr1_ID, sr2_ID,
             memread_EX, regwrite_EX, destreg_EX,
             imem_busy, dmem_busy, redirect_MEM,
      input  load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
             bubble_ID_EX, flush_IF_ID, redirect_pc, hz_state, stall_count
   );

   modport slave (
      input  needs_sr1_ID, needs_sr2_ID, sr1_ID, sr2_ID,
             memread_EX, regwrite_EX, destreg_EX,
             imem_busy, dmem_busy, redirect_MEM,
      output load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
             bubble_ID_EX, flush_IF_ID, redirect_pc, hz_state, stall_count
   );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID-stage source read of a register a load in EX is about to write.
module load_use_detect
   import lc3b_types::*;
(
   input  logic    needs_sr1,
   input  logic    needs_sr2,
   input  lc3b_reg sr1,
   input  lc3b_reg sr2,
   input  logic    memread,
   input  logic    regwrite,
   input  lc3b_reg destreg,
   output logic    load_use_c
);

   logic sr1_hit_c;
   logic sr2_hit_c;

   always_comb begin
      sr1_hit_c  = needs_sr1 & (sr1 == destreg);
      sr2_hit_c  = needs_sr2 & (sr2 == destreg);
      load_use_c = memread & regwrite & (sr1_hit_c | sr2_hit_c);
   end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: stall/bubble/flush/redirect sequencing and stall counter.
module hazard_control
   import lc3b_types::*;
(
   input  logic              clk,
   input  logic              reset_n,
   hazard_control_if.slave   hz
);

   lc3b_hz_state           state_q, state_d;
   logic                   pending_q, pending_d;
   logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

   logic                   load_use_c;
   logic                   redirect_go_c;

   load_use_detect u_load_use_detect (
      .needs_sr1  (hz.needs_sr1_ID),
      .needs_sr2  (hz.needs_sr2_ID),
      .sr1        (hz.sr1_ID),
      .sr2        (hz.sr2_ID),
      .memread    (hz.memread_EX),
      .regwrite   (hz.regwrite_EX),
      .destreg    (hz.destreg_EX),
      .load_use_c (load_use_c)
   );

   // A redirect seen while dmem stalls is remembered until the stall clears
   assign redirect_go_c = hz.redirect_MEM | pending_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= HZ_RUN;
         pending_q     <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         stall_count_q <= stall_count_d;
      end
   end

   always_comb begin
      state_d   = HZ_RUN;
      pending_d = 1'b0;
      if (hz.dmem_busy) begin
         state_d   = HZ_DMEM_WAIT;
         pending_d = pending_q | hz.redirect_MEM;
      end else if (redirect_go_c) begin
         state_d   = HZ_REDIRECT;
      end else if (state_q == HZ_REDIRECT) begin
         state_d   = HZ_RUN;
      end else if (load_use_c) begin
         state_d   = HZ_RUN;
      end else if (hz.imem_busy) begin
         state_d   = HZ_IMEM_WAIT;
      end
   end

   always_comb begin
      hz.load_pc      = 1'b1;
      hz.load_IF_ID   = 1'b1;
      hz.load_ID_EX   = 1'b1;
      hz.load_EX_MEM  = 1'b1;
      hz.load_MEM_WB  = 1'b1;
      hz.bubble_ID_EX = 1'b0;
      hz.flush_IF_ID  = 1'b0;
      hz.redirect_pc  = 1'b0;
      if (!reset_n) begin
         hz.load_pc      = 1'b0;
         hz.load_IF_ID   = 1'b0;
         hz.load_ID_EX   = 1'b0;
         hz.load_EX_MEM  = 1'b0;
         hz.load_MEM_WB  = 1'b0;
         hz.bubble_ID_EX = 1'b1;
         hz.flush_IF_ID  = 1'b1;
      end else if (hz.dmem_busy) begin
         hz.load_pc      = 1'b0;
         hz.load_IF_ID   = 1'b0;
         hz.load_ID_EX   = 1'b0;
         hz.load_EX_MEM  = 1'b0;
         hz.load_MEM_WB  = 1'b0;
      end else if (redirect_go_c) begin
         hz.bubble_ID_EX = 1'b1;
         hz.flush_IF_ID  = 1'b1;
         hz.redirect_pc  = 1'b1;
      end else if (state_q == HZ_REDIRECT) begin
         // Squash the wrong-path fetch that was in flight during the redirect
         hz.flush_IF_ID  = 1'b1;
      end else if (load_use_c || hz.imem_busy) begin
         hz.load_pc      = 1'b0;
         hz.load_IF_ID   = 1'b0;
         hz.bubble_ID_EX = 1'b1;
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (!hz.load_pc && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + STALL_CNT_W'(1);
      end
   end

   assign hz.hz_state    = state_q;
   assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_control.sv
// Randomized + directed bench for hazard_control against a rule-level reference model.
module tb_hazard_control;
   import lc3b_types::*;

   logic clk = 1'b0;
   logic reset_n;

   hazard_control_if hif ();

   hazard_control dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: what the pipeline has experienced, not how the RTL encodes it
   lc3b_hz_state m_state;
   bit           m_pending;
   logic [15:0]  m_stalls;

   // Last sampled DUT view (taken mid-cycle by step)
   logic [7:0]   obs_vec;
   lc3b_hz_state obs_state;
   logic [15:0]  obs_stall;

   localparam logic [7:0] V_RESET = 8'b00000_110;
   localparam logic [7:0] V_RUN   = 8'b11111_000;
   localparam logic [7:0] V_HOLD  = 8'b00000_000;
   localparam logic [7:0] V_REDIR = 8'b11111_111;
   localparam logic [7:0] V_POSTR = 8'b11111_010;
   localparam logic [7:0] V_STALL = 8'b00111_100;

   function automatic bit model_load_use();
      bit hit1, hit2;
      hit1 = hif.needs_sr1_ID && (hif.sr1_ID == hif.destreg_EX);
      hit2 = hif.needs_sr2_ID && (hif.sr2_ID == hif.destreg_EX);
      return hif.memread_EX && hif.regwrite_EX && (hit1 || hit2);
   endfunction

   // Expected {load_pc,IF_ID,ID_EX,EX_MEM,MEM_WB,bubble,flush,redirect_pc}
   function automatic logic [7:0] model_outs();
      if (!reset_n)                            return V_RESET;
      if (hif.dmem_busy)                       return V_HOLD;
      if (hif.redirect_MEM || m_pending)       return V_REDIR;
      if (m_state == HZ_REDIRECT)              return V_POSTR;
      if (model_load_use() || hif.imem_busy)   return V_STALL;
      return V_RUN;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hif.needs_sr1_ID = 1'b0;
      hif.needs_sr2_ID = 1'b0;
      hif.sr1_ID       = '0;
      hif.sr2_ID       = '0;
      hif.memread_EX   = 1'b0;
      hif.regwrite_EX  = 1'b0;
      hif.destreg_EX   = '0;
      hif.imem_busy    = 1'b0;
      hif.dmem_busy    = 1'b0;
      hif.redirect_MEM = 1'b0;
   endtask

   // One clock: sample/compare at negedge, advance model across posedge
   task automatic step(input bit do_check);
      logic [7:0]   exp;
      lc3b_hz_state n_state;
      bit           n_pending;
      logic [15:0]  n_stalls;
      @(negedge clk);
      exp       = model_outs();
      obs_vec   = {hif.load_pc, hif.load_IF_ID, hif.load_ID_EX, hif.load_EX_MEM,
                   hif.load_MEM_WB, hif.bubble_ID_EX, hif.flush_IF_ID, hif.redirect_pc};
      obs_state = hif.hz_state;
      obs_stall = hif.stall_count;
      if (do_check) begin
         chk("model_outs",  16'(obs_vec), 16'(exp));
         chk("model_state", 16'(obs_state), 16'(m_state));
         chk("model_stall", obs_stall, m_stalls);
      end
      if (!reset_n) begin
         n_state = HZ_RUN; n_pending = 1'b0; n_stalls = 16'd0;
      end else begin
         n_stalls  = (exp[7] == 1'b0 && m_stalls != 16'hFFFF) ? m_stalls + 16'd1 : m_stalls;
         n_pending = hif.dmem_busy ? (m_pending || hif.redirect_MEM) : 1'b0;
         if (hif.dmem_busy)                      n_state = HZ_DMEM_WAIT;
         else if (hif.redirect_MEM || m_pending) n_state = HZ_REDIRECT;
         else if (m_state == HZ_REDIRECT)        n_state = HZ_RUN;
         else if (model_load_use())              n_state = HZ_RUN;
         else if (hif.imem_busy)                 n_state = HZ_IMEM_WAIT;
         else                                    n_state = HZ_RUN;
      end
      @(posedge clk);
      m_state = n_state; m_pending = n_pending; m_stalls = n_stalls;
      #1;
   endtask

   initial begin
      logic [15:0] s0;
      m_state = HZ_RUN; m_pending = 1'b0; m_stalls = 16'd0;
      idle();
      reset_n = 1'b0;

      // Reset: outputs forced, then clean RUN state
      step(1'b0);
      chk("reset_outs", 16'(obs_vec), 16'(V_RESET));
      step(1'b1);
      reset_n = 1'b1;
      step(1'b1);
      chk("post_reset_state", 16'(obs_state), 16'(HZ_RUN));
      chk("post_reset_stall", obs_stall, 16'd0);
      chk("post_reset_outs", 16'(obs_vec), 16'(V_RUN));

      // Single load-use bubble
      hif.memread_EX = 1'b1; hif.regwrite_EX = 1'b1; hif.destreg_EX = 3'd3;
      hif.needs_sr1_ID = 1'b1; hif.sr1_ID = 3'd3;
      step(1'b1);
      chk("lu_outs", 16'(obs_vec), 16'(V_STALL));
      idle();
      step(1'b1);
      chk("lu_after_outs", 16'(obs_vec), 16'(V_RUN));
      chk("lu_stall_cnt", obs_stall, 16'd1);

      // Same registers but no source read: no stall
      hif.memread_EX = 1'b1; hif.regwrite_EX = 1'b1; hif.destreg_EX = 3'd3;
      hif.needs_sr1_ID = 1'b0; hif.sr1_ID = 3'd3;
      step(1'b1);
      chk("no_lu_outs", 16'(obs_vec), 16'(V_RUN));
      idle();
      step(1'b1);

      // dmem stall with redirect arriving in its first cycle
      s0 = m_stalls;
      hif.dmem_busy = 1'b1; hif.redirect_MEM = 1'b1;
      step(1'b1);
      chk("dmem_c1", 16'(obs_vec), 16'(V_HOLD));
      hif.redirect_MEM = 1'b0;
      step(1'b1);
      chk("dmem_c2", 16'(obs_vec), 16'(V_HOLD));
      step(1'b1);
      chk("dmem_c3", 16'(obs_vec), 16'(V_HOLD));
      hif.dmem_busy = 1'b0;
      step(1'b1);
      chk("dmem_c4_redirect", 16'(obs_vec), 16'(V_REDIR));
      chk("dmem_c4_state", 16'(obs_state), 16'(HZ_DMEM_WAIT));
      step(1'b1);
      chk("dmem_c5_state", 16'(obs_state), 16'(HZ_REDIRECT));
      chk("dmem_c5_outs", 16'(obs_vec), 16'(V_POSTR));
      chk("dmem_stall_cnt", obs_stall, s0 + 16'd3);
      step(1'b1);
      chk("dmem_c6_state", 16'(obs_state), 16'(HZ_RUN));

      // Two-cycle imem stall
      s0 = m_stalls;
      hif.imem_busy = 1'b1;
      step(1'b1);
      chk("imem_c1", 16'(obs_vec), 16'(V_STALL));
      step(1'b1);
      chk("imem_c2", 16'(obs_vec), 16'(V_STALL));
      chk("imem_c2_state", 16'(obs_state), 16'(HZ_IMEM_WAIT));
      hif.imem_busy = 1'b0;
      step(1'b1);
      chk("imem_done_state", 16'(obs_state), 16'(HZ_IMEM_WAIT));
      chk("imem_stall_cnt", obs_stall, s0 + 16'd2);
      chk("imem_done_outs", 16'(obs_vec), 16'(V_RUN));

      // Redirect while waiting on imem takes effect at once
      hif.imem_busy = 1'b1;
      step(1'b1);
      hif.redirect_MEM = 1'b1;
      step(1'b1);
      chk("imem_redirect", 16'(obs_vec), 16'(V_REDIR));
      idle();
      step(1'b1);
      chk("imem_redirect_state", 16'(obs_state), 16'(HZ_REDIRECT));

      // Reset during dmem wait with redirect pending drops the redirect
      hif.dmem_busy = 1'b1; hif.redirect_MEM = 1'b1;
      step(1'b1);
      hif.redirect_MEM = 1'b0;
      step(1'b1);
      reset_n = 1'b0;
      step(1'b1);
      chk("rst_pend_outs", 16'(obs_vec), 16'(V_RESET));
      reset_n = 1'b1; hif.dmem_busy = 1'b0;
      step(1'b1);
      chk("rst_pend_state", 16'(obs_state), 16'(HZ_RUN));
      chk("rst_pend_no_redirect", 16'(obs_vec), 16'(V_RUN));
      chk("rst_pend_stall", obs_stall, 16'd0);
      step(1'b1);
      chk("rst_pend_no_redirect2", 16'(obs_vec), 16'(V_RUN));

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         hif.dmem_busy    = ($urandom_range(7) == 0);
         hif.redirect_MEM = ($urandom_range(9) == 0);
         hif.imem_busy    = ($urandom_range(4) == 0);
         hif.memread_EX   = $urandom_range(1) == 1;
         hif.regwrite_EX  = $urandom_range(1) == 1;
         hif.needs_sr1_ID = $urandom_range(1) == 1;
         hif.needs_sr2_ID = $urandom_range(1) == 1;
         hif.sr1_ID       = lc3b_reg'($urandom_range(7));
         hif.sr2_ID       = lc3b_reg'($urandom_range(7));
         hif.destreg_EX   = lc3b_reg'($urandom_range(7));
         reset_n          = ($urandom_range(99) != 0);
         step(1'b1);
      end
      idle();
      reset_n = 1'b1;
      step(1'b1);

      // Long dmem stall saturates the counter
      reset_n = 1'b0;
      step(1'b1);
      reset_n = 1'b1;
      hif.dmem_busy = 1'b1;
      for (int i = 0; i < 65540; i++) step(1'b0);
      step(1'b1);
      chk("sat_stall", obs_stall, 16'hFFFF);
      step(1'b1);
      chk("sat_stall_hold", obs_stall, 16'hFFFF);
      hif.dmem_busy = 1'b0;
      step(1'b1);
      step(1'b1);
      chk("sat_stall_idle", obs_stall, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
